// File: rtl/modinv_check.sv
// modinv_check: consumer-side checker for extended-GCD results.
// Computes (a*inv) mod b bit-serially and flags whether it equals gcd mod b.
// Optional feature macro: MODINV_CHECK_FAILCNT_EN adds the saturating fail_cnt output.
module modinv_check #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  input  logic [W-1:0] gcd_in,
  input  logic [W-1:0] inv_in,
  output logic         busy,
  output logic [W-1:0] prod_mod,
  output logic         pass,
  output logic         err,
  output logic         valid_out
`ifdef MODINV_CHECK_FAILCNT_EN
  ,
  output logic [7:0]   fail_cnt
`endif
);

  localparam int unsigned AW = W + 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_SIGN,
    S_MUL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    i_sh_q, i_sh_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    gcd_q, gcd_d;
  logic            neg_q, neg_d;
  logic            bad_q, bad_d;
  logic [AW-1:0]   acc_a_q, acc_a_d;
  logic [AW-1:0]   acc_i_q, acc_i_d;
  logic [AW-1:0]   p_q, p_d;
  logic            busy_d;
  logic [W-1:0]    prod_d;
  logic            pass_d;
  logic            err_d;
  logic            vout_d;
  logic            cap_bad_c;
  logic [W-1:0]    inv_mag_c;
  logic [AW-1:0]   gcd_red_c;

  // One MSB-first reduction step: r = 2r + bit, then conditional subtract of b.
  function automatic logic [AW-1:0] red_step(input logic [AW-1:0] r,
                                             input logic          bit_in,
                                             input logic [W-1:0]  b);
    logic [AW-1:0] t;
    t = (r << 1) | AW'(bit_in);
    if (t >= AW'(b)) t = t - AW'(b);
    return t;
  endfunction

  // One interleaved modular-multiply step: double, reduce, optionally add and reduce.
  function automatic logic [AW-1:0] mul_step(input logic [AW-1:0] p,
                                             input logic          bit_in,
                                             input logic [AW-1:0] addend,
                                             input logic [W-1:0]  b);
    logic [AW-1:0] t;
    t = p << 1;
    if (t >= AW'(b)) t = t - AW'(b);
    if (bit_in) begin
      t = t + addend;
      if (t >= AW'(b)) t = t - AW'(b);
    end
    return t;
  endfunction

  // Input qualification and magnitude of the signed coefficient.
  always_comb begin
    cap_bad_c = (data_b == '0) || (gcd_in > data_b);
    inv_mag_c = inv_in[W-1] ? W'(~inv_in + W'(1)) : inv_in;
    gcd_red_c = (gcd_q == b_q) ? '0 : AW'(gcd_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    i_sh_d  = i_sh_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    neg_d   = neg_q;
    bad_d   = bad_q;
    acc_a_d = acc_a_q;
    acc_i_d = acc_i_q;
    p_d     = p_q;
    busy_d  = busy;
    prod_d  = prod_mod;
    pass_d  = pass;
    err_d   = err;
    vout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          a_sh_d  = data_a;
          i_sh_d  = inv_mag_c;
          b_d     = data_b;
          gcd_d   = gcd_in;
          neg_d   = inv_in[W-1];
          bad_d   = cap_bad_c;
          acc_a_d = '0;
          acc_i_d = '0;
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = cap_bad_c ? S_DONE : S_RED;
        end
      end

      S_RED: begin
        acc_a_d = red_step(acc_a_q, a_sh_q[W-1], b_q);
        acc_i_d = red_step(acc_i_q, i_sh_q[W-1], b_q);
        a_sh_d  = a_sh_q << 1;
        i_sh_d  = i_sh_q << 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = S_SIGN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SIGN: begin
        if (neg_q && (acc_i_q != '0)) acc_i_d = AW'(b_q) - acc_i_q;
        state_d = S_MUL;
      end

      S_MUL: begin
        p_d     = mul_step(p_q, acc_a_q[W-1], acc_i_q, b_q);
        acc_a_d = acc_a_q << 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        vout_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (bad_q) begin
          prod_d = '0;
          pass_d = 1'b0;
          err_d  = 1'b1;
        end else begin
          prod_d = p_q[W-1:0];
          pass_d = (p_q == gcd_red_c);
          err_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      a_sh_q    <= '0;
      i_sh_q    <= '0;
      b_q       <= '0;
      gcd_q     <= '0;
      neg_q     <= 1'b0;
      bad_q     <= 1'b0;
      acc_a_q   <= '0;
      acc_i_q   <= '0;
      p_q       <= '0;
      busy      <= 1'b0;
      prod_mod  <= '0;
      pass      <= 1'b0;
      err       <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      i_sh_q    <= i_sh_d;
      b_q       <= b_d;
      gcd_q     <= gcd_d;
      neg_q     <= neg_d;
      bad_q     <= bad_d;
      acc_a_q   <= acc_a_d;
      acc_i_q   <= acc_i_d;
      p_q       <= p_d;
      busy      <= busy_d;
      prod_mod  <= prod_d;
      pass      <= pass_d;
      err       <= err_d;
      valid_out <= vout_d;
    end
  end

`ifdef MODINV_CHECK_FAILCNT_EN
  // Saturating count of results that failed or were flagged invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
    end else if ((state_q == S_DONE) && (err_d || !pass_d) && (fail_cnt != 8'hFF)) begin
      fail_cnt <= fail_cnt + 8'd1;
    end
  end
`endif

endmodule
